// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller feeding the fetch-stage PC mux: masks, prioritises
// (lowest index wins), presents a vector and saves EPC/NZCV on acknowledge. Macro: IRQ_SYNC_EN.
module int_ctrl #(
   parameter int          N_IRQ      = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0004
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic [N_IRQ-1:0] IRQ,
   input  logic             Mask_Wr,
   input  logic [N_IRQ-1:0] Mask_In,
   input  logic [31:0]      PC,
   input  logic [4:1]       NZCV,
   input  logic             INT_Ack,
   input  logic             INT_Ret,
   output logic             INT_Req,
   output logic [31:0]      INT_Vector,
   output logic [2:0]       INT_ID,
   output logic [31:0]      EPC,
   output logic [4:1]       Saved_NZCV,
   output logic             In_Service,
   output logic [N_IRQ-1:0] Pending
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_REQ     = 2'b01,
      S_SERVICE = 2'b10
   } state_t;

   localparam logic [N_IRQ-1:0] IRQ_ONE = N_IRQ'(1'b1);

   state_t             state_r;
   state_t             state_nxt_s;
   logic               load_s;
   logic               ack_take_s;
   logic [N_IRQ-1:0]   irq_s;
   logic [N_IRQ-1:0]   irq_prev_r;
   logic [N_IRQ-1:0]   rise_s;
   logic [N_IRQ-1:0]   clr_s;
   logic [N_IRQ-1:0]   mask_r;
   logic [N_IRQ-1:0]   pending_r;
   logic [N_IRQ-1:0]   eligible_s;
   logic [2:0]         winner_s;
   logic [31:0]        vector_s;
   logic               int_req_r;
   logic               in_service_r;
   logic [2:0]         int_id_r;
   logic [31:0]        int_vector_r;
   logic [31:0]        epc_r;
   logic [4:1]         saved_nzcv_r;

   // Lowest set index of v; 0 when v is empty (caller only uses it when v != 0).
   function automatic logic [2:0] first_set(input logic [N_IRQ-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

`ifdef IRQ_SYNC_EN
   logic [N_IRQ-1:0] sync1_r;
   logic [N_IRQ-1:0] sync2_r;

   // Two-flop synchronizer for asynchronous interrupt lines.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= IRQ;
         sync2_r <= sync1_r;
      end
   end

   assign irq_s = sync2_r;
`else
   assign irq_s = IRQ;
`endif

   assign rise_s     = irq_s & ~irq_prev_r;
   assign eligible_s = pending_r & mask_r;
   assign winner_s   = first_set(eligible_s);
   assign vector_s   = VEC_BASE + (32'(winner_s) * VEC_STRIDE);
   assign clr_s      = ack_take_s ? (IRQ_ONE << int_id_r) : '0;

   // Edge history, mask register and pending latch (a new edge beats a same-cycle clear).
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         irq_prev_r <= '0;
         mask_r     <= '0;
         pending_r  <= '0;
      end else begin
         irq_prev_r <= irq_s;
         pending_r  <= (pending_r & ~clr_s) | rise_s;
         if (Mask_Wr) begin
            mask_r <= Mask_In;
         end
      end
   end

   // Next-state decode; the winner is only sampled on the IDLE->REQ transition.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      ack_take_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (|eligible_s) begin
               state_nxt_s = S_REQ;
               load_s      = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (INT_Ack) begin
               state_nxt_s = S_SERVICE;
               ack_take_s  = 1'b1;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_SERVICE: begin
            if (INT_Ret) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_SERVICE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register plus registered request/status, vector and return context.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state_r      <= S_IDLE;
         int_req_r    <= 1'b0;
         in_service_r <= 1'b0;
         int_id_r     <= 3'd0;
         int_vector_r <= VEC_BASE;
         epc_r        <= 32'd0;
         saved_nzcv_r <= 4'd0;
      end else begin
         state_r      <= state_nxt_s;
         int_req_r    <= (state_nxt_s == S_REQ);
         in_service_r <= (state_nxt_s == S_SERVICE);
         if (load_s) begin
            int_id_r     <= winner_s;
            int_vector_r <= vector_s;
         end
         if (ack_take_s) begin
            epc_r        <= PC;
            saved_nzcv_r <= NZCV;
         end
      end
   end

   assign INT_Req    = int_req_r;
   assign In_Service = in_service_r;
   assign INT_ID     = int_id_r;
   assign INT_Vector = int_vector_r;
   assign EPC        = epc_r;
   assign Saved_NZCV = saved_nzcv_r;
   assign Pending    = pending_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus pushes expected request/acknowledge records,
// a negedge monitor pops and compares them when INT_Req or In_Service rise.
module tb_int_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        rst;
   logic [3:0]  irq;
   logic        mask_wr;
   logic [3:0]  mask_in;
   logic [31:0] pc;
   logic [4:1]  nzcv;
   logic        int_ack;
   logic        int_ret;
   logic        int_req;
   logic [31:0] int_vector;
   logic [2:0]  int_id;
   logic [31:0] epc;
   logic [4:1]  saved_nzcv;
   logic        in_service;
   logic [3:0]  pending;

   int n_tests = 0;
   int n_fail  = 0;

   logic [34:0] req_q[$];
   logic [35:0] svc_q[$];
   logic        req_prev = 1'b0;
   logic        svc_prev = 1'b0;

   int_ctrl #(.N_IRQ(4), .VEC_BASE(32'h0000_0080), .VEC_STRIDE(32'h0000_0004)) dut (
      .clk(clk), .Rst(rst), .IRQ(irq), .Mask_Wr(mask_wr), .Mask_In(mask_in),
      .PC(pc), .NZCV(nzcv), .INT_Ack(int_ack), .INT_Ret(int_ret),
      .INT_Req(int_req), .INT_Vector(int_vector), .INT_ID(int_id), .EPC(epc),
      .Saved_NZCV(saved_nzcv), .In_Service(in_service), .Pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare vector on each request rise, saved context on each service entry.
   always @(negedge clk) begin
      logic [34:0] re;
      logic [35:0] se;
      if (int_req && !req_prev) begin
         if (req_q.size() == 0) begin
            check("unexpected_req", {29'd0, int_id}, 32'hFFFF_FFFF);
         end else begin
            re = req_q.pop_front();
            check("req_id", {29'd0, int_id}, {29'd0, re[34:32]});
            check("req_vector", int_vector, re[31:0]);
         end
      end
      if (in_service && !svc_prev) begin
         if (svc_q.size() == 0) begin
            check("unexpected_service", epc, 32'hFFFF_FFFF);
         end else begin
            se = svc_q.pop_front();
            check("epc", epc, se[35:4]);
            check("saved_nzcv", {28'd0, saved_nzcv}, {28'd0, se[3:0]});
         end
      end
      req_prev = int_req;
      svc_prev = in_service;
   end

   task automatic write_mask(input logic [3:0] m);
      mask_wr = 1'b1;
      mask_in = m;
      tick();
      mask_wr = 1'b0;
   endtask

   // One-cycle pulse on the given lines, expect the request exactly LAT posedges later.
   task automatic pulse_expect_req(input logic [3:0] lines, input string name);
      irq = lines;
      tick();
      irq = 4'b0000;
      repeat (LAT - 2) tick();
      check({name, "_early"}, {31'd0, int_req}, 32'd0);
      tick();
      check({name, "_lat"}, {31'd0, int_req}, 32'd1);
   endtask

   task automatic do_ack(input logic [31:0] p, input logic [3:0] f);
      pc      = p;
      nzcv    = f;
      int_ack = 1'b1;
      svc_q.push_back({p, f});
      tick();
      int_ack = 1'b0;
      check("ack_in_service", {31'd0, in_service}, 32'd1);
      check("ack_req_low", {31'd0, int_req}, 32'd0);
   endtask

   task automatic do_ret();
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;
      check("ret_in_service", {31'd0, in_service}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; irq = 4'b0000; mask_wr = 1'b0; mask_in = 4'b0000;
      pc = 32'd0; nzcv = 4'b0000; int_ack = 1'b0; int_ret = 1'b0;
      repeat (3) tick();
      check("rst_req", {31'd0, int_req}, 32'd0);
      check("rst_vector", int_vector, 32'h0000_0080);
      check("rst_pending", {28'd0, pending}, 32'd0);
      rst = 1'b0;
      tick();

      // Single source
      write_mask(4'b1111);
      req_q.push_back({3'd2, 32'h0000_0088});
      pulse_expect_req(4'b0100, "irq2");
      do_ack(32'h0000_0040, 4'b1010);
      check("ack_pending_clr", {28'd0, pending}, 32'd0);
      do_ret();

      // Simultaneous sources: lowest index first, the other follows after return
      req_q.push_back({3'd1, 32'h0000_0084});
      pulse_expect_req(4'b1010, "irq31");
      check("both_pending", {28'd0, pending}, 32'h0000_000A);
      do_ack(32'h0000_0100, 4'b0101);
      check("pending_after_ack", {28'd0, pending}, 32'h0000_0008);
      req_q.push_back({3'd3, 32'h0000_008C});
      do_ret();
      check("second_req_gap", {31'd0, int_req}, 32'd0);
      tick();
      check("second_req", {31'd0, int_req}, 32'd1);
      do_ack(32'h0000_0200, 4'b1111);
      do_ret();

      // Masked source held pending, released by mask write
      write_mask(4'b0000);
      irq = 4'b0001;
      tick();
      irq = 4'b0000;
      repeat (LAT) tick();
      check("masked_pending", {28'd0, pending}, 32'h0000_0001);
      check("masked_no_req", {31'd0, int_req}, 32'd0);
      req_q.push_back({3'd0, 32'h0000_0080});
      write_mask(4'b0001);
      check("unmask_early", {31'd0, int_req}, 32'd0);
      tick();
      check("unmask_req", {31'd0, int_req}, 32'd1);
      write_mask(4'b0000);
      check("req_held_masked", {31'd0, int_req}, 32'd1);

      // Ack and Ret together in REQ: ack taken, ret ignored
      pc = 32'h0000_0300; nzcv = 4'b0011;
      svc_q.push_back({32'h0000_0300, 4'b0011});
      int_ack = 1'b1; int_ret = 1'b1;
      tick();
      int_ack = 1'b0; int_ret = 1'b0;
      check("ackret_service", {31'd0, in_service}, 32'd1);

      // No nesting: edge during SERVICE only pends
      write_mask(4'b1111);
      irq = 4'b0001;
      tick();
      irq = 4'b0000;
      repeat (LAT) tick();
      check("nest_no_req", {31'd0, int_req}, 32'd0);
      check("nest_pending", {28'd0, pending}, 32'h0000_0001);
      check("nest_service", {31'd0, in_service}, 32'd1);
      req_q.push_back({3'd0, 32'h0000_0080});
      do_ret();
      check("post_ret_idle", {31'd0, int_req}, 32'd0);
      tick();
      check("post_ret_req", {31'd0, int_req}, 32'd1);

      // Ret in REQ ignored
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;
      check("ret_in_req_ignored", {31'd0, int_req}, 32'd1);

      // Async reset in REQ takes effect before the next edge
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_req", {31'd0, int_req}, 32'd0);
      check("arst_id", {29'd0, int_id}, 32'd0);
      check("arst_vector", int_vector, 32'h0000_0080);
      check("arst_epc", epc, 32'd0);
      check("arst_nzcv", {28'd0, saved_nzcv}, 32'd0);
      check("arst_pending", {28'd0, pending}, 32'd0);
      check("arst_service", {31'd0, in_service}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Ack/Ret in IDLE ignored
      pc = 32'hDEAD_BEEF; nzcv = 4'b1001;
      int_ack = 1'b1; int_ret = 1'b1;
      tick();
      int_ack = 1'b0; int_ret = 1'b0;
      tick();
      check("idle_ack_req", {31'd0, int_req}, 32'd0);
      check("idle_ack_service", {31'd0, in_service}, 32'd0);
      check("idle_ack_epc", epc, 32'd0);

      repeat (2) tick();
      check("req_q_drained", req_q.size(), 32'd0);
      check("svc_q_drained", svc_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller directly upstream of the instruction-fetch/PC stage.
- Latches edge-triggered IRQ lines, applies a mask and fixed priority, and raises a request to the control unit.
- Drives the vector that the fetch stage loads into PC when PC_s=2'b11.
- On acknowledge, captures return PC and NZCV for the return-from-interrupt path; one interrupt in service at a time, no nesting.

Parameters:
N_IRQ, 4, number of interrupt sources (1..8)
VEC_BASE, 32'h0000_0080, address of vector for source 0
VEC_STRIDE, 32'h0000_0004, byte distance between consecutive source vectors

Ports:
clk  input  1  clock; all state updates on posedge
Rst  input  1  asynchronous active-high reset
IRQ  input  N_IRQ  interrupt lines, rising-edge sensitive
Mask_Wr  input  1  write strobe for mask register
Mask_In  input  N_IRQ  new mask value (1 = source enabled)
PC  input  32  current PC from fetch stage, captured as return address
NZCV  input  4 [4:1]  current flags, captured on acknowledge
INT_Ack  input  1  control unit has taken the vector (asserted in the cycle it writes PC with PC_s=2'b11)
INT_Ret  input  1  return-from-interrupt executed
INT_Req  output  1  interrupt request to control unit
INT_Vector  output  32  vector address for fetch stage
INT_ID  output  3  index of latched/serviced source
EPC  output  32  saved return PC
Saved_NZCV  output  4 [4:1]  saved flags
In_Service  output  1  handler currently active
Pending  output  N_IRQ  pending bits (debug/status)

Behaviour:
- Reset (async, immediate, also mid-operation): state IDLE; INT_Req=0, In_Service=0, INT_ID=0, INT_Vector=VEC_BASE, EPC=0, Saved_NZCV=0, Pending=0, mask=0 (all disabled), edge history=0.
- Edge detect: irq_prev <= IRQ every posedge. IRQ[i] & ~irq_prev[i] sets Pending[i]. Pending latches regardless of mask or state.
- Set and clear of the same bit in one cycle: set wins.
- Mask: on Mask_Wr, mask <= Mask_In at posedge. Masked pending bits are held, not dropped.
- Eligible = Pending & mask. Priority is fixed: lowest index wins.
- INT_Vector = VEC_BASE + INT_ID*VEC_STRIDE, 32-bit arithmetic, wrap-around allowed. Registered; stable from REQ entry through SERVICE.
- FSM:
  IDLE: INT_Req=0, In_Service=0. If Eligible != 0, latch INT_ID = winner, load INT_Vector, go REQ.
  REQ: INT_Req=1. Winner is frozen: no re-arbitration, and the request is not withdrawn even if a mask write disables the source. On INT_Ack: EPC<=PC, Saved_NZCV<=NZCV, clear Pending[INT_ID], go SERVICE.
  SERVICE: INT_Req=0, In_Service=1. New edges latch but raise no request (no nesting). On INT_Ret go IDLE; the next request can rise the following cycle.
- INT_Ack outside REQ is ignored. INT_Ret outside SERVICE is ignored. INT_Ack and INT_Ret together in REQ: ack taken, ret ignored.
- Latency: IRQ low at posedge k-1 and high at posedge k (enabled, IDLE) -> Pending set after k -> INT_Req=1 after k+1.
- Ack to In_Service: one posedge. EPC/Saved_NZCV hold until the next acknowledge or reset.

Optional Feature:
- IRQ_SYNC_EN defined: IRQ passes through a 2-flop synchronizer (reset 0) before edge detect. IRQ-to-INT_Req latency becomes 4 posedges.
- Undefined: IRQ feeds edge detect directly; latency 2 posedges.

Test Plan:
- Reset, then mask=4'b1111, pulse IRQ[2] -> INT_Req=1 two posedges later, INT_ID=2, INT_Vector=32'h88.
- IRQ[3] and IRQ[1] rise same cycle -> INT_ID=1, INT_Vector=32'h84. After ack+ret, a second request with INT_ID=3, INT_Vector=32'h8C.
- In REQ with PC=32'h0000_0040, NZCV=4'b1010, assert INT_Ack -> EPC=32'h40, Saved_NZCV=4'b1010, In_Service=1, INT_Req=0, Pending[id]=0.
- mask=4'b0000, pulse IRQ[0] -> Pending=4'b0001, INT_Req stays 0. Write mask=4'b0001 -> INT_Req=1 two posedges after the write.
- In SERVICE, pulse IRQ[0] -> no request; INT_Ret -> IDLE then INT_Req=1 next posedge. Assert Rst in REQ -> all outputs at reset values immediately.
- IRQ_SYNC_EN defined: IRQ[1] rise -> INT_Req after 4 posedges; INT_Ret asserted in IDLE -> no state change.
